// File: rtl/ecc_host_link.sv
// Host-side serial link: serializes P/a and Pb operand frames to the ECC
// accelerator and deserializes its Pa/Pab result streams into words.

module ecc_host_link_rx #(
  parameter int MAX_BITS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8:0]          n_i,
  input  logic                valid_i,
  input  logic                x_i,
  input  logic                y_i,
  output logic                done_o,
  output logic [MAX_BITS-1:0] x_o,
  output logic [MAX_BITS-1:0] y_o,
  output logic                trunc_o
);

  logic [MAX_BITS-1:0] shx_q;
  logic [MAX_BITS-1:0] shy_q;
  logic [MAX_BITS-1:0] shx_d;
  logic [MAX_BITS-1:0] shy_d;
  logic [8:0]          cnt_q;
  logic [8:0]          cnt_d;

  assign shx_d   = {shx_q[MAX_BITS-2:0], x_i};
  assign shy_d   = {shy_q[MAX_BITS-2:0], y_i};
  assign cnt_d   = cnt_q + 9'd1;
  assign trunc_o = !valid_i && (cnt_q != 9'd0);

  // Shifters are cleared between words so a captured word is zero-extended.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shx_q  <= '0;
      shy_q  <= '0;
      cnt_q  <= '0;
      done_o <= 1'b0;
      x_o    <= '0;
      y_o    <= '0;
    end else begin
      done_o <= 1'b0;
      if (valid_i) begin
        if (cnt_d >= n_i) begin
          x_o    <= shx_d;
          y_o    <= shy_d;
          done_o <= 1'b1;
          cnt_q  <= '0;
          shx_q  <= '0;
          shy_q  <= '0;
        end else begin
          shx_q <= shx_d;
          shy_q <= shy_d;
          cnt_q <= cnt_d;
        end
      end else if (cnt_q != 9'd0) begin
        cnt_q <= '0;
        shx_q <= '0;
        shy_q <= '0;
      end
    end
  end

endmodule

module ecc_host_link #(
  parameter int MAX_BITS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_mode,
  input  logic [MAX_BITS-1:0] req_P,
  input  logic [MAX_BITS-1:0] req_ax,
  input  logic [MAX_BITS-1:0] req_ay,
  input  logic [MAX_BITS-1:0] req_prime,
  input  logic                pb_req_valid,
  output logic                pb_req_ready,
  input  logic [MAX_BITS-1:0] pb_x,
  input  logic [MAX_BITS-1:0] pb_y,
  output logic                o_p_a_valid,
  output logic                o_pb_valid,
  output logic                o_mode,
  output logic                o_P,
  output logic                o_ax,
  output logic                o_ay,
  output logic                o_prime,
  output logic                o_Pbx,
  output logic                o_Pby,
  input  logic                i_Pa_valid,
  input  logic                i_Pab_valid,
  input  logic                i_Pax,
  input  logic                i_Pay,
  input  logic                i_Pabx,
  input  logic                i_Paby,
  output logic                pa_valid,
  output logic                pab_valid,
  output logic [MAX_BITS-1:0] pa_x,
  output logic [MAX_BITS-1:0] pa_y,
  output logic [MAX_BITS-1:0] pab_x,
  output logic [MAX_BITS-1:0] pab_y,
  output logic                rx_err
);

  typedef enum logic [2:0] {
    IDLE, PA_START, MODE, PA_DATA, PB_START, PB_DATA, GAP
  } tx_state_e;

  tx_state_e           state_q;
  logic [1:0]          mode_q;
  logic [7:0]          cnt_q;
  logic [7:0]          cnt_dn;
  logic [7:0]          nm1;
  logic [8:0]          n_bits;
  logic [MAX_BITS-1:0] p_q;
  logic [MAX_BITS-1:0] ax_q;
  logic [MAX_BITS-1:0] ay_q;
  logic [MAX_BITS-1:0] pr_q;
  logic [MAX_BITS-1:0] bx_q;
  logic [MAX_BITS-1:0] by_q;
  logic                pa_trunc;
  logic                pab_trunc;

  // N-1 is 31/63/127/255: low five bits always set.
  assign nm1    = {&mode_q, mode_q[1], |mode_q, 5'h1f};
  assign n_bits = {1'b0, nm1} + 9'd1;
  assign cnt_dn = cnt_q - 8'd1;

  assign req_ready    = (state_q == IDLE);
  assign pb_req_ready = (state_q == IDLE) && !req_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      ax_q        <= '0;
      ay_q        <= '0;
      pr_q        <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      o_p_a_valid <= 1'b0;
      o_pb_valid  <= 1'b0;
      o_mode      <= 1'b0;
      o_P         <= 1'b0;
      o_ax        <= 1'b0;
      o_ay        <= 1'b0;
      o_prime     <= 1'b0;
      o_Pbx       <= 1'b0;
      o_Pby       <= 1'b0;
    end else begin
      o_p_a_valid <= 1'b0;
      o_pb_valid  <= 1'b0;
      o_mode      <= 1'b0;
      o_P         <= 1'b0;
      o_ax        <= 1'b0;
      o_ay        <= 1'b0;
      o_prime     <= 1'b0;
      o_Pbx       <= 1'b0;
      o_Pby       <= 1'b0;
      // Lanes are set for the state being entered, so they align with it.
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            mode_q      <= req_mode;
            p_q         <= req_P;
            ax_q        <= req_ax;
            ay_q        <= req_ay;
            pr_q        <= req_prime;
            o_p_a_valid <= 1'b1;
            state_q     <= PA_START;
          end else if (pb_req_valid) begin
            bx_q       <= pb_x;
            by_q       <= pb_y;
            o_pb_valid <= 1'b1;
            state_q    <= PB_START;
          end
        end
        PA_START: begin
          o_mode  <= mode_q[1];
          cnt_q   <= '0;
          state_q <= MODE;
        end
        MODE: begin
          if (cnt_q == 8'd0) begin
            o_mode <= mode_q[0];
            cnt_q  <= 8'd1;
          end else begin
            o_P     <= p_q[nm1];
            o_ax    <= ax_q[nm1];
            o_ay    <= ay_q[nm1];
            o_prime <= pr_q[nm1];
            cnt_q   <= nm1;
            state_q <= PA_DATA;
          end
        end
        PA_DATA: begin
          if (cnt_q == 8'd0) begin
            state_q <= GAP;
          end else begin
            o_P     <= p_q[cnt_dn];
            o_ax    <= ax_q[cnt_dn];
            o_ay    <= ay_q[cnt_dn];
            o_prime <= pr_q[cnt_dn];
            cnt_q   <= cnt_dn;
          end
        end
        PB_START: begin
          o_Pbx   <= bx_q[nm1];
          o_Pby   <= by_q[nm1];
          cnt_q   <= nm1;
          state_q <= PB_DATA;
        end
        PB_DATA: begin
          if (cnt_q == 8'd0) begin
            state_q <= GAP;
          end else begin
            o_Pbx <= bx_q[cnt_dn];
            o_Pby <= by_q[cnt_dn];
            cnt_q <= cnt_dn;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  ecc_host_link_rx #(.MAX_BITS(MAX_BITS)) u_rx_pa (
    .clk     (clk),
    .rst     (rst),
    .n_i     (n_bits),
    .valid_i (i_Pa_valid),
    .x_i     (i_Pax),
    .y_i     (i_Pay),
    .done_o  (pa_valid),
    .x_o     (pa_x),
    .y_o     (pa_y),
    .trunc_o (pa_trunc)
  );

  ecc_host_link_rx #(.MAX_BITS(MAX_BITS)) u_rx_pab (
    .clk     (clk),
    .rst     (rst),
    .n_i     (n_bits),
    .valid_i (i_Pab_valid),
    .x_i     (i_Pabx),
    .y_i     (i_Paby),
    .done_o  (pab_valid),
    .x_o     (pab_x),
    .y_o     (pab_y),
    .trunc_o (pab_trunc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_err <= 1'b0;
    else      rx_err <= pa_trunc | pab_trunc;
  end

endmodule

// File: tb/tb_ecc_host_link.sv
// Randomized bench for ecc_host_link: frames and result words are
// predicted from the link timing rules and compared every cycle.

module tb_ecc_host_link;

  localparam int MB = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_mode = '0;
  logic [MB-1:0] req_P = '0;
  logic [MB-1:0] req_ax = '0;
  logic [MB-1:0] req_ay = '0;
  logic [MB-1:0] req_prime = '0;
  logic          pb_req_valid = 1'b0;
  logic          pb_req_ready;
  logic [MB-1:0] pb_x = '0;
  logic [MB-1:0] pb_y = '0;
  logic          o_p_a_valid, o_pb_valid, o_mode;
  logic          o_P, o_ax, o_ay, o_prime, o_Pbx, o_Pby;
  logic          i_Pa_valid = 1'b0;
  logic          i_Pab_valid = 1'b0;
  logic          i_Pax = 1'b0;
  logic          i_Pay = 1'b0;
  logic          i_Pabx = 1'b0;
  logic          i_Paby = 1'b0;
  logic          pa_valid, pab_valid, rx_err;
  logic [MB-1:0] pa_x, pa_y, pab_x, pab_y;

  ecc_host_link #(.MAX_BITS(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mode     (req_mode),
    .req_P        (req_P),
    .req_ax       (req_ax),
    .req_ay       (req_ay),
    .req_prime    (req_prime),
    .pb_req_valid (pb_req_valid),
    .pb_req_ready (pb_req_ready),
    .pb_x         (pb_x),
    .pb_y         (pb_y),
    .o_p_a_valid  (o_p_a_valid),
    .o_pb_valid   (o_pb_valid),
    .o_mode       (o_mode),
    .o_P          (o_P),
    .o_ax         (o_ax),
    .o_ay         (o_ay),
    .o_prime      (o_prime),
    .o_Pbx        (o_Pbx),
    .o_Pby        (o_Pby),
    .i_Pa_valid   (i_Pa_valid),
    .i_Pab_valid  (i_Pab_valid),
    .i_Pax        (i_Pax),
    .i_Pay        (i_Pay),
    .i_Pabx       (i_Pabx),
    .i_Paby       (i_Paby),
    .pa_valid     (pa_valid),
    .pab_valid    (pab_valid),
    .pa_x         (pa_x),
    .pa_y         (pa_y),
    .pab_x        (pab_x),
    .pab_y        (pab_y),
    .rx_err       (rx_err)
  );

  always #5 clk = ~clk;

  logic [8:0] lanes;
  assign lanes = {o_p_a_valid, o_pb_valid, o_mode, o_P, o_ax,
                  o_ay, o_prime, o_Pbx, o_Pby};

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [1:0]    cur_mode;
  logic [MB-1:0] m_pax, m_pay, m_pabx, m_paby;

  task automatic chk(input string tag, input logic [MB-1:0] got,
                     input logic [MB-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbits(input logic [1:0] m);
    return 32 << m;
  endfunction

  function automatic logic [MB-1:0] rnd();
    logic [MB-1:0] r;
    for (int i = 0; i < MB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [MB-1:0] trim(input logic [MB-1:0] v, input int n);
    logic [MB-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_pax = '0; m_pay = '0; m_pabx = '0; m_paby = '0;
    cur_mode = 2'b00;
    chk("rst_lanes", MB'(lanes), '0);
    chk("rst_flags", MB'({pa_valid, pab_valid, rx_err}), '0);
    chk("rst_pa_x", pa_x, '0);
    chk("rst_pa_y", pa_y, '0);
    chk("rst_pab_x", pab_x, '0);
    chk("rst_pab_y", pab_y, '0);
    chk("rst_ready", MB'(req_ready), MB'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic expect_pa(input logic [1:0] m, input logic [MB-1:0] p,
                           input logic [MB-1:0] ax, input logic [MB-1:0] ay,
                           input logic [MB-1:0] pr);
    int n;
    logic [8:0] e;
    n = nbits(m);
    for (int c = 1; c <= n + 4; c++) begin
      @(negedge clk);
      e = '0;
      if (c == 1) e[8] = 1'b1;
      else if (c == 2) e[6] = m[1];
      else if (c == 3) e[6] = m[0];
      else if (c <= n + 3) begin
        int k;
        k = n + 3 - c;
        e[5] = p[k]; e[4] = ax[k]; e[3] = ay[k]; e[2] = pr[k];
      end
      chk("pa_lanes", MB'(lanes), MB'(e));
      chk("pa_busy", MB'(req_ready), '0);
    end
    @(negedge clk);
    chk("pa_ready_back", MB'(req_ready), MB'(1));
  endtask

  task automatic expect_pb(input logic [MB-1:0] x, input logic [MB-1:0] y);
    int n;
    logic [8:0] e;
    n = nbits(cur_mode);
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      e = '0;
      if (c == 1) e[7] = 1'b1;
      else if (c <= n + 1) begin
        int k;
        k = n + 1 - c;
        e[1] = x[k]; e[0] = y[k];
      end
      chk("pb_lanes", MB'(lanes), MB'(e));
      chk("pb_busy", MB'(pb_req_ready), '0);
    end
    @(negedge clk);
    chk("pb_ready_back", MB'(req_ready), MB'(1));
  endtask

  task automatic send_pa(input logic [1:0] m, input logic [MB-1:0] p,
                         input logic [MB-1:0] ax, input logic [MB-1:0] ay,
                         input logic [MB-1:0] pr);
    req_valid = 1'b1; req_mode = m;
    req_P = p; req_ax = ax; req_ay = ay; req_prime = pr;
    #1;
    chk("pa_ready", MB'(req_ready), MB'(1));
    if (pb_req_valid) chk("pb_blocked", MB'(pb_req_ready), '0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cur_mode = m;
    expect_pa(m, p, ax, ay, pr);
  endtask

  task automatic send_pb(input logic [MB-1:0] x, input logic [MB-1:0] y);
    pb_req_valid = 1'b1; pb_x = x; pb_y = y;
    #1;
    chk("pb_ready", MB'(pb_req_ready), MB'(1));
    @(posedge clk);
    #1 pb_req_valid = 1'b0;
    expect_pb(x, y);
  endtask

  task automatic rx_word(input bit pab, input int len,
                         input logic [MB-1:0] x, input logic [MB-1:0] y);
    int n;
    n = nbits(cur_mode);
    for (int i = 0; i < len; i++) begin
      if (pab) begin
        i_Pab_valid = 1'b1; i_Pabx = x[n-1-i]; i_Paby = y[n-1-i];
      end else begin
        i_Pa_valid = 1'b1; i_Pax = x[n-1-i]; i_Pay = y[n-1-i];
      end
      @(negedge clk);
    end
    i_Pa_valid = 1'b0; i_Pab_valid = 1'b0;
    i_Pax = 1'b0; i_Pay = 1'b0; i_Pabx = 1'b0; i_Paby = 1'b0;
    if (len == n) begin
      if (pab) begin m_pabx = trim(x, n); m_paby = trim(y, n); end
      else     begin m_pax  = trim(x, n); m_pay  = trim(y, n); end
      chk("rx_done", MB'({pa_valid, pab_valid}), MB'(pab ? 2'b01 : 2'b10));
    end
    chk("rx_pa_x", pa_x, m_pax);
    chk("rx_pa_y", pa_y, m_pay);
    chk("rx_pab_x", pab_x, m_pabx);
    chk("rx_pab_y", pab_y, m_paby);
    @(negedge clk);
    chk("rx_err", MB'(rx_err), MB'(len != n));
    chk("rx_pulse_end", MB'({pa_valid, pab_valid}), '0);
    chk("rx_keep_pa_x", pa_x, m_pax);
    chk("rx_keep_pab_x", pab_x, m_pabx);
    @(negedge clk);
    chk("rx_err_end", MB'(rx_err), '0);
  endtask

  initial begin
    logic [MB-1:0] p, ax, ay, pr;
    do_reset();

    send_pa(2'b00, 256'h8000_0001, 256'hDEAD_BEEF, 256'h1, 256'hFFFF_FFFB);
    send_pa(2'b01, rnd(), rnd(), rnd(), rnd());
    send_pb(256'h0123_4567_89AB_CDEF, rnd());

    pb_req_valid = 1'b1; pb_x = rnd(); pb_y = rnd();
    p = pb_x; ax = pb_y;
    send_pa(2'b00, rnd(), rnd(), rnd(), rnd());
    send_pb(p, ax);

    rx_word(1'b0, 32, 256'hCAFE_F00D, rnd());
    rx_word(1'b1, 10, rnd(), rnd());

    for (int i = 0; i < 7; i++) begin
      i_Pa_valid = 1'b1; i_Pab_valid = 1'b1;
      i_Pax = 1'($urandom); i_Pabx = 1'($urandom);
      @(negedge clk);
    end
    i_Pa_valid = 1'b0; i_Pab_valid = 1'b0;
    @(negedge clk);
    chk("dual_trunc_err", MB'(rx_err), MB'(1));
    @(negedge clk);
    chk("dual_trunc_single", MB'(rx_err), '0);
    chk("dual_trunc_words", pab_x, m_pabx);

    p = rnd();
    req_valid = 1'b1; req_mode = 2'b11; req_P = p;
    req_ax = rnd(); req_ay = rnd(); req_prime = rnd();
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (159) @(negedge clk);
    chk("mid_bit100", MB'(o_P), MB'(p[100]));
    do_reset();
    chk("post_rst_ready", MB'(req_ready), MB'(1));
    send_pa(2'b00, rnd(), rnd(), rnd(), rnd());

    send_pa(2'b10, rnd(), rnd(), rnd(), rnd());
    rx_word(1'b1, 128, rnd(), rnd());

    for (int it = 0; it < 40; it++) begin
      int op;
      op = int'($urandom_range(0, 3));
      if (op == 0) begin
        send_pa(2'($urandom), rnd(), rnd(), rnd(), rnd());
      end else if (op == 1) begin
        send_pb(rnd(), rnd());
      end else begin
        int n;
        int len;
        n = nbits(cur_mode);
        len = ($urandom_range(0, 1) == 0) ? n : int'($urandom_range(1, n - 1));
        rx_word(op == 3, len, rnd(), rnd());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
